// File: rtl/cfg_pkg.sv
// Shared definitions for the fabric configuration loader.
//   cfg_state_t : loader FSM state encoding
//   chain_len() : config-chain length derived from cell count and bits per cell
//   DEF_CELLS / DEF_BITS_PER_CELL : default fabric geometry (16 cells x 4 bits = 64)
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_LATCH  = 3'd3,
        ST_SETTLE = 3'd4,
        ST_DONE   = 3'd5
    } cfg_state_t;

    localparam int DEF_CELLS         = 16;
    localparam int DEF_BITS_PER_CELL = 4;

    function automatic int chain_len(input int cells, input int bits_per_cell);
        return cells * bits_per_cell;
    endfunction

endpackage

// File: rtl/cfg_shifter.sv
// Word shifter for the fabric configuration loader.
// Holds one configuration word and presents it MSB-first.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   load        : capture word into the shift register, restart the bit counter
//   shift       : shift left by one (bit WORD_W-1 leaves first)
//   word        : parallel word input
//   msb         : current serial bit (shift register MSB)
//   word_empty  : high while the last bit of the word sits at the MSB, i.e. a shift
//                 this cycle empties the register
module cfg_shifter
    import cfg_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [WORD_W-1:0] word,
    output logic              msb,
    output logic              word_empty
);

    localparam int BW = $clog2(WORD_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(WORD_W - 1);

    logic [WORD_W-1:0] shreg_reg;
    logic [BW-1:0]     bit_cnt_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_reg   <= '0;
            bit_cnt_reg <= '0;
        end else if (load) begin
            shreg_reg   <= word;
            bit_cnt_reg <= '0;
        end else if (shift) begin
            shreg_reg   <= {shreg_reg[WORD_W-2:0], 1'b0};
            bit_cnt_reg <= bit_cnt_reg + BW'(1);
        end
    end

    assign msb        = shreg_reg[WORD_W-1];
    assign word_empty = (bit_cnt_reg == LAST_BIT);

endmodule

// File: rtl/fabric_config_loader.sv
// Fabric configuration loader.
// Accepts configuration words on a valid/ready stream, shifts them MSB-first into
// the fabric's serial config chain, pulses the chain latch, then keeps the fabric
// in reset for a settle period before releasing it.
// Ports:
//   i_Clock, i_Reset : clock, asynchronous active-high reset
//   i_Start          : begin (re)configuration, honoured in IDLE and DONE
//   i_Abort          : cancel load, return to IDLE (wins over i_Start)
//   i_WordValid/i_Word, o_WordReady : input word stream
//   o_CfgData, o_CfgShift, o_CfgLatch : serial config chain interface
//   o_FabricReset    : fabric user-logic reset
//   o_Busy, o_Done   : status
//   o_BitCount       : bits shifted since the last start
// All outputs are decoded from registered state only.
module fabric_config_loader
    import cfg_pkg::*;
#(
    parameter int CHAIN_LEN         = chain_len(DEF_CELLS, DEF_BITS_PER_CELL),
    parameter int WORD_W            = 8,
    parameter int POST_LATCH_CYCLES = 4,
    localparam int CNT_W            = $clog2(CHAIN_LEN + 1)
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic              i_Abort,
    input  logic              i_WordValid,
    input  logic [WORD_W-1:0] i_Word,
    output logic              o_WordReady,
    output logic              o_CfgData,
    output logic              o_CfgShift,
    output logic              o_CfgLatch,
    output logic              o_FabricReset,
    output logic              o_Busy,
    output logic              o_Done,
    output logic [CNT_W-1:0]  o_BitCount
);

    localparam int SW = $clog2(POST_LATCH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CHAIN_END   = CNT_W'(CHAIN_LEN);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(POST_LATCH_CYCLES - 1);

    cfg_state_t       state_reg, state_next;
    logic [CNT_W-1:0] bit_count_reg, bit_count_next, bit_count_inc;
    logic [SW-1:0]    settle_reg, settle_next;
    logic             load_word;
    logic             shifting;
    logic             shift_msb;
    logic             word_empty;

    assign shifting      = (state_reg == ST_SHIFT);
    assign bit_count_inc = bit_count_reg + CNT_W'(1);

    cfg_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk        (i_Clock),
        .rst        (i_Reset),
        .load       (load_word),
        .shift      (shifting),
        .word       (i_Word),
        .msb        (shift_msb),
        .word_empty (word_empty)
    );

    always_comb begin
        state_next     = state_reg;
        bit_count_next = bit_count_reg;
        settle_next    = settle_reg;
        load_word      = 1'b0;

        // A SHIFT cycle always presents a shift pulse to the chain (outputs are
        // registered decodes), so that bit is counted even if an abort arrives.
        if (shifting) begin
            bit_count_next = bit_count_inc;
        end

        case (state_reg)
            ST_IDLE: begin
                if (i_Start && !i_Abort) begin
                    state_next     = ST_LOAD;
                    bit_count_next = '0;
                end
            end
            ST_LOAD: begin
                // With abort, a presented word is still handshaken but dropped.
                if (i_Abort) begin
                    state_next = ST_IDLE;
                end else if (i_WordValid) begin
                    load_word  = 1'b1;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (i_Abort) begin
                    state_next = ST_IDLE;
                end else if (bit_count_inc == CHAIN_END) begin
                    // Any bits left in the word are discarded.
                    state_next = ST_LATCH;
                end else if (word_empty) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LATCH: begin
                if (i_Abort) begin
                    state_next = ST_IDLE;
                end else begin
                    state_next  = ST_SETTLE;
                    settle_next = '0;
                end
            end
            ST_SETTLE: begin
                if (i_Abort) begin
                    state_next = ST_IDLE;
                end else if (settle_reg == SETTLE_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    settle_next = settle_reg + SW'(1);
                end
            end
            ST_DONE: begin
                if (i_Abort) begin
                    state_next = ST_IDLE;
                end else if (i_Start) begin
                    state_next     = ST_LOAD;
                    bit_count_next = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_reg     <= ST_IDLE;
            bit_count_reg <= '0;
            settle_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            bit_count_reg <= bit_count_next;
            settle_reg    <= settle_next;
        end
    end

    assign o_WordReady   = (state_reg == ST_LOAD);
    assign o_CfgShift    = shifting;
    assign o_CfgData     = shifting & shift_msb;
    assign o_CfgLatch    = (state_reg == ST_LATCH);
    assign o_FabricReset = (state_reg != ST_DONE);
    assign o_Busy        = (state_reg == ST_LOAD) || (state_reg == ST_SHIFT) ||
                           (state_reg == ST_LATCH) || (state_reg == ST_SETTLE);
    assign o_Done        = (state_reg == ST_DONE);
    assign o_BitCount    = bit_count_reg;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Directed testbench for fabric_config_loader.
// Main instance: CHAIN_LEN=12, WORD_W=8, POST_LATCH_CYCLES=4.
// Second instance: CHAIN_LEN=8 for the single-word case.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_fabric_config_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, abort, wvalid;
    logic [7:0] word;
    logic       wready, cdata, cshift, clatch, freset, busy, done;
    logic [3:0] bcnt;

    logic       start8, abort8, wvalid8;
    logic [7:0] word8;
    logic       wready8, cdata8, cshift8, clatch8, freset8, busy8, done8;
    logic [3:0] bcnt8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fabric_config_loader #(
        .CHAIN_LEN         (12),
        .WORD_W            (8),
        .POST_LATCH_CYCLES (4)
    ) dut (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Start       (start),
        .i_Abort       (abort),
        .i_WordValid   (wvalid),
        .i_Word        (word),
        .o_WordReady   (wready),
        .o_CfgData     (cdata),
        .o_CfgShift    (cshift),
        .o_CfgLatch    (clatch),
        .o_FabricReset (freset),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_BitCount    (bcnt)
    );

    fabric_config_loader #(
        .CHAIN_LEN         (8),
        .WORD_W            (8),
        .POST_LATCH_CYCLES (4)
    ) dut8 (
        .i_Clock       (clk),
        .i_Reset       (rst),
        .i_Start       (start8),
        .i_Abort       (abort8),
        .i_WordValid   (wvalid8),
        .i_Word        (word8),
        .o_WordReady   (wready8),
        .o_CfgData     (cdata8),
        .o_CfgShift    (cshift8),
        .o_CfgLatch    (clatch8),
        .o_FabricReset (freset8),
        .o_Busy        (busy8),
        .o_Done        (done8),
        .o_BitCount    (bcnt8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full load from IDLE/DONE with two words. gap = ready cycles withheld before
    // the second word; hold_start keeps i_Start high while busy (must be ignored);
    // rst_in_settle asserts the async reset in the first SETTLE cycle instead of
    // waiting for DONE.
    task automatic do_load(input string tag, input logic [7:0] w0, input logic [7:0] w1,
                           input int gap, input bit hold_start, input bit rst_in_settle,
                           input logic [11:0] exp_stream);
        logic [11:0] stream;
        int pulses, idx, gap_left, cyc, latch_cyc, last_shift_cyc, done_cyc;
        int latches, settle_cyc, stall_cyc, bad_stall, overlap;
        bit finished;
        stream = '0; pulses = 0; idx = 0; gap_left = gap; cyc = 0;
        latch_cyc = -1; last_shift_cyc = -1; done_cyc = -1;
        latches = 0; settle_cyc = 0; stall_cyc = 0; bad_stall = 0; overlap = 0;
        finished = 1'b0;

        start = 1'b1;
        wvalid = 1'b0;
        @(negedge clk);
        if (!hold_start) start = 1'b0;
        chk({tag, " ready_after_start"}, wready, 1);
        chk({tag, " freset_after_start"}, freset, 1);
        chk({tag, " done_after_start"}, done, 0);
        chk({tag, " bcnt_cleared"}, bcnt, 0);

        while (!finished && cyc < 200) begin
            if (cshift) begin
                stream = {stream[10:0], cdata};
                pulses++;
                last_shift_cyc = cyc;
            end
            if (cshift && wready) overlap++;
            if (clatch) begin
                latches++;
                latch_cyc = cyc;
            end else if (latches > 0 && freset && busy) begin
                settle_cyc++;
            end
            if (done) begin
                done_cyc = cyc;
                finished = 1'b1;
            end else if (rst_in_settle && latches > 0 && !clatch) begin
                finished = 1'b1;
            end
            wvalid = 1'b0;
            if (wready && !finished) begin
                if (idx == 1) begin
                    stall_cyc++;
                    if (bcnt != 4'd8) bad_stall++;
                end
                if (idx == 0) begin
                    wvalid = 1'b1;
                    word = w0;
                    idx = 1;
                end else if (idx == 1) begin
                    if (gap_left == 0) begin
                        wvalid = 1'b1;
                        word = w1;
                        idx = 2;
                    end else begin
                        gap_left--;
                    end
                end
            end
            if (!finished) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        wvalid = 1'b0;
        chk({tag, " completed_in_budget"}, finished, 1);

        if (rst_in_settle) begin
            #2 rst = 1'b1;
            #1;
            chk({tag, " rst_freset"}, freset, 1);
            chk({tag, " rst_busy"}, busy, 0);
            chk({tag, " rst_done"}, done, 0);
            chk({tag, " rst_bcnt"}, bcnt, 0);
            chk({tag, " rst_cshift"}, cshift, 0);
            chk({tag, " rst_wready"}, wready, 0);
            repeat (3) @(negedge clk);
            chk({tag, " rst_done_held"}, done, 0);
            rst = 1'b0;
            @(negedge clk);
            chk({tag, " after_rst_done"}, done, 0);
            chk({tag, " after_rst_busy"}, busy, 0);
            $display("[%0t] %s: reset in settle, pulses=%0d", $time, tag, pulses);
        end else begin
            chk({tag, " stream"}, stream, exp_stream);
            chk({tag, " pulses"}, pulses, 12);
            chk({tag, " latch_count"}, latches, 1);
            chk({tag, " latch_after_last_shift"}, latch_cyc - last_shift_cyc, 1);
            chk({tag, " settle_cycles"}, settle_cyc, 4);
            chk({tag, " done_after_latch"}, done_cyc - latch_cyc, 5);
            chk({tag, " ready_shift_overlap"}, overlap, 0);
            chk({tag, " bcnt_done"}, bcnt, 12);
            chk({tag, " freset_done"}, freset, 0);
            chk({tag, " busy_done"}, busy, 0);
            if (gap > 0) begin
                chk({tag, " stall_cycles"}, stall_cyc, gap + 1);
                chk({tag, " stall_bcnt_8"}, bad_stall, 0);
            end
            $display("[%0t] %s: stream=%03h pulses=%0d latch@%0d done@%0d", $time, tag,
                     stream, pulses, latch_cyc, done_cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, latches, shifts, readys, ready_again, accepted;
        bit seen;
        logic [7:0] stream8;

        rst = 1'b1;
        start = 0; abort = 0; wvalid = 0; word = 0;
        start8 = 0; abort8 = 0; wvalid8 = 0; word8 = 0;

        // Reset values
        @(negedge clk);
        chk("reset freset", freset, 1);
        chk("reset bcnt", bcnt, 0);
        chk("reset wready", wready, 0);
        chk("reset cshift", cshift, 0);
        chk("reset cdata", cdata, 0);
        chk("reset clatch", clatch, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset8 freset", freset8, 1);
        rst = 1'b0;
        @(negedge clk);
        chk("idle busy", busy, 0);
        $display("[%0t] reset checks done", $time);

        // Basic load, then a stalled load with Start held high, then FF/FF from DONE
        do_load("basic", 8'hA5, 8'h3C, 0, 1'b0, 1'b0, 12'hA53);
        do_load("gap5", 8'hA5, 8'h3C, 5, 1'b1, 1'b0, 12'hA53);
        do_load("ones", 8'hFF, 8'hFF, 0, 1'b0, 1'b0, 12'hFFF);

        // Abort after 5 shifts
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            if (cshift) pulses++;
            wvalid = wready;
            word = 8'hA5;
            if (pulses == 5) begin
                abort = 1'b1;
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        chk("abort reached_5", seen, 1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", busy, 0);
        chk("abort freset", freset, 1);
        chk("abort cshift", cshift, 0);
        chk("abort wready", wready, 0);
        chk("abort bcnt", bcnt, 5);
        // Valid held high while idle must not start anything
        wvalid = 1'b1;
        word = 8'h00;
        latches = 0; shifts = 0; readys = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (clatch) latches++;
            if (cshift) shifts++;
            if (wready) readys++;
        end
        wvalid = 1'b0;
        chk("abort no_latch", latches, 0);
        chk("abort no_shift", shifts, 0);
        chk("abort no_ready", readys, 0);
        $display("[%0t] abort: idle after 5 shifts, bcnt=%0d", $time, bcnt);
        do_load("reload", 8'h3C, 8'hA5, 0, 1'b0, 1'b0, 12'h3CA);

        // Async reset during SETTLE, then a normal load from IDLE
        do_load("settle_rst", 8'hA5, 8'h3C, 0, 1'b0, 1'b1, 12'h000);
        do_load("post_rst", 8'h3C, 8'hA5, 0, 1'b0, 1'b0, 12'h3CA);

        // CHAIN_LEN=8, single word
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        pulses = 0; latches = 0; ready_again = 0; accepted = 0; stream8 = '0;
        seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            if (cshift8) begin
                stream8 = {stream8[6:0], cdata8};
                pulses++;
            end
            wvalid8 = 1'b0;
            if (wready8) begin
                if (accepted != 0) begin
                    ready_again++;
                end else begin
                    wvalid8 = 1'b1;
                    word8 = 8'h81;
                    accepted = 1;
                end
            end
            if (clatch8) begin
                latches++;
                seen = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        wvalid8 = 1'b0;
        chk("chain8 latched", seen, 1);
        chk("chain8 pulses", pulses, 8);
        chk("chain8 stream", stream8, 8'h81);
        chk("chain8 ready_again", ready_again, 0);
        chk("chain8 bcnt", bcnt8, 8);
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (done8) seen = 1'b1;
        end
        chk("chain8 done", seen, 1);
        chk("chain8 freset", freset8, 0);
        $display("[%0t] chain8: stream=%02h pulses=%0d", $time, stream8, pulses);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
